// File: rtl/message_telemetry_engine_if.sv
`default_nettype none
// =============================================================================
// Module   : message_telemetry_engine_if
// Brief    : RX command, sensor-channel, TX reply and control-output bundle
//            shared between the telemetry engine and its surroundings.
// Revision : 1.0 - initial release
// =============================================================================
interface message_telemetry_engine_if #(
    parameter int BYTE_WIDTH  = 8,
    parameter int WORD_WIDTH  = 17,
    parameter int N_CHANNELS  = 16,
    parameter int N_WAYPOINTS = 8
);
    localparam int c_WAY_W = (N_WAYPOINTS > 1) ? $clog2(N_WAYPOINTS) : 1;

    logic                             MSG_TELEMETRY_RXVALID_InHigh;
    logic [BYTE_WIDTH-1:0]            MSG_TELEMETRY_RXDATA_InBus;
    logic [N_CHANNELS*WORD_WIDTH-1:0] MSG_TELEMETRY_CHANNELS_InBus;
    logic                             MSG_TELEMETRY_TXREADY_InHigh;
    logic [BYTE_WIDTH-1:0]            MSG_TELEMETRY_TXDATA_OutBus;
    logic                             MSG_TELEMETRY_TXVALID_OutHigh;
    logic                             MSG_TELEMETRY_BUSY_OutHigh;
    logic [c_WAY_W-1:0]               MSG_TELEMETRY_WAYSELECT_OutBus;
    logic                             MSG_TELEMETRY_STOPSIGNAL_OutLow;
    logic                             MSG_TELEMETRY_BEGINSIGNAL_OutLow;
    logic                             MSG_TELEMETRY_DROP_OutHigh;

    // The engine masters the TX stream and the control outputs.
    modport master (
        input  MSG_TELEMETRY_RXVALID_InHigh,
        input  MSG_TELEMETRY_RXDATA_InBus,
        input  MSG_TELEMETRY_CHANNELS_InBus,
        input  MSG_TELEMETRY_TXREADY_InHigh,
        output MSG_TELEMETRY_TXDATA_OutBus,
        output MSG_TELEMETRY_TXVALID_OutHigh,
        output MSG_TELEMETRY_BUSY_OutHigh,
        output MSG_TELEMETRY_WAYSELECT_OutBus,
        output MSG_TELEMETRY_STOPSIGNAL_OutLow,
        output MSG_TELEMETRY_BEGINSIGNAL_OutLow,
        output MSG_TELEMETRY_DROP_OutHigh
    );

    modport slave (
        output MSG_TELEMETRY_RXVALID_InHigh,
        output MSG_TELEMETRY_RXDATA_InBus,
        output MSG_TELEMETRY_CHANNELS_InBus,
        output MSG_TELEMETRY_TXREADY_InHigh,
        input  MSG_TELEMETRY_TXDATA_OutBus,
        input  MSG_TELEMETRY_TXVALID_OutHigh,
        input  MSG_TELEMETRY_BUSY_OutHigh,
        input  MSG_TELEMETRY_WAYSELECT_OutBus,
        input  MSG_TELEMETRY_STOPSIGNAL_OutLow,
        input  MSG_TELEMETRY_BEGINSIGNAL_OutLow,
        input  MSG_TELEMETRY_DROP_OutHigh
    );
endinterface
`default_nettype wire

// File: rtl/message_telemetry_engine.sv
`default_nettype none
// =============================================================================
// Module   : message_telemetry_engine
// Brief    : Decodes robot command bytes and serialises framed telemetry
//            replies (code echo + MSB-first payload) with a one-deep pending slot.
// Revision : 1.0 - initial release
// =============================================================================
module message_telemetry_engine #(
    parameter int BYTE_WIDTH     = 8,
    parameter int WORD_WIDTH     = 17,
    parameter int BYTES_PER_WORD = 3,
    parameter int N_WAYPOINTS    = 8,
    parameter int N_CHANNELS     = 16,
    parameter int STOP_CODE      = 9,
    parameter int BEGIN_CODE     = 10,
    parameter int TELEM_BASE     = 32
) (
    input logic                        MSG_TELEMETRY_CLOCK_50,
    input logic                        MSG_TELEMETRY_RESET_InLow,
    message_telemetry_engine_if.master bus
);
    localparam int c_PAYLOAD_W = BYTES_PER_WORD * BYTE_WIDTH;
    localparam int c_WAY_W     = (N_WAYPOINTS > 1) ? $clog2(N_WAYPOINTS) : 1;
    localparam int c_CH_W      = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int c_CNT_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    localparam logic [c_CNT_W-1:0] c_LAST_BYTE = c_CNT_W'(BYTES_PER_WORD - 1);
    localparam logic [31:0] c_WAY_HI   = 32'(N_WAYPOINTS);
    localparam logic [31:0] c_STOP     = 32'(STOP_CODE);
    localparam logic [31:0] c_BEGIN    = 32'(BEGIN_CODE);
    localparam logic [31:0] c_TELEM_LO = 32'(TELEM_BASE);
    localparam logic [31:0] c_TELEM_HI = 32'(TELEM_BASE + N_CHANNELS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PAY  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_PAYLOAD_W-1:0]  r_shift;
    logic [c_CNT_W-1:0]      r_cnt;
    logic                    r_pendValid;
    logic [BYTE_WIDTH-1:0]   r_pendCode;
    logic [c_PAYLOAD_W-1:0]  r_pendData;
    logic [c_WAY_W-1:0]      r_waySelect;
    logic                    r_stop;
    logic                    r_begin;
    logic                    r_drop;
    logic                    r_txValid;
    logic [BYTE_WIDTH-1:0]   r_txData;

    logic [31:0]             w_codeExt;
    logic                    w_isWay;
    logic                    w_isStop;
    logic                    w_isBegin;
    logic                    w_isTelem;
    logic                    w_txFire;
    logic [c_CH_W-1:0]       w_chanIdx;
    logic [WORD_WIDTH-1:0]   w_chanWords [N_CHANNELS];
    logic [c_PAYLOAD_W-1:0]  w_snap;

    genvar gi;
    generate
        for (gi = 0; gi < N_CHANNELS; gi++) begin : g_chan
            assign w_chanWords[gi] = bus.MSG_TELEMETRY_CHANNELS_InBus[gi*WORD_WIDTH +: WORD_WIDTH];
        end
    endgenerate

    assign w_codeExt = 32'(bus.MSG_TELEMETRY_RXDATA_InBus);
    assign w_isWay   = bus.MSG_TELEMETRY_RXVALID_InHigh && (w_codeExt >= 32'd1) && (w_codeExt <= c_WAY_HI);
    assign w_isStop  = bus.MSG_TELEMETRY_RXVALID_InHigh && (w_codeExt == c_STOP);
    assign w_isBegin = bus.MSG_TELEMETRY_RXVALID_InHigh && (w_codeExt == c_BEGIN);
    assign w_isTelem = bus.MSG_TELEMETRY_RXVALID_InHigh && (w_codeExt >= c_TELEM_LO) && (w_codeExt < c_TELEM_HI);
    assign w_chanIdx = c_CH_W'(w_codeExt - c_TELEM_LO);
    assign w_snap    = c_PAYLOAD_W'(w_chanWords[w_chanIdx]);
    assign w_txFire  = r_txValid && bus.MSG_TELEMETRY_TXREADY_InHigh;

    always_ff @(posedge MSG_TELEMETRY_CLOCK_50 or negedge MSG_TELEMETRY_RESET_InLow) begin
        if (!MSG_TELEMETRY_RESET_InLow) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_pendValid <= 1'b0;
            r_pendCode  <= '0;
            r_pendData  <= '0;
            r_waySelect <= '0;
            r_stop      <= 1'b0;
            r_begin     <= 1'b1;
            r_drop      <= 1'b0;
            r_txValid   <= 1'b0;
            r_txData    <= '0;
        end else begin
            r_begin <= !w_isBegin;
            if (w_isWay)   r_waySelect <= c_WAY_W'(w_codeExt - 32'd1);
            if (w_isStop)  r_stop      <= 1'b0;
            if (w_isBegin) r_stop      <= 1'b1;

            // Requests arriving mid-reply park in the pending slot or are dropped.
            if (w_isTelem && (r_state != S_IDLE)) begin
                if (r_pendValid) begin
                    r_drop <= 1'b1;
                end else begin
                    r_pendValid <= 1'b1;
                    r_pendCode  <= bus.MSG_TELEMETRY_RXDATA_InBus;
                    r_pendData  <= w_snap;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (r_pendValid) begin
                        r_state   <= S_HDR;
                        r_txValid <= 1'b1;
                        r_txData  <= r_pendCode;
                        r_shift   <= r_pendData;
                        if (w_isTelem) begin
                            r_pendCode <= bus.MSG_TELEMETRY_RXDATA_InBus;
                            r_pendData <= w_snap;
                        end else begin
                            r_pendValid <= 1'b0;
                        end
                    end else if (w_isTelem) begin
                        r_state   <= S_HDR;
                        r_txValid <= 1'b1;
                        r_txData  <= bus.MSG_TELEMETRY_RXDATA_InBus;
                        r_shift   <= w_snap;
                    end
                end
                S_HDR: begin
                    if (w_txFire) begin
                        r_state  <= S_PAY;
                        r_cnt    <= '0;
                        r_txData <= r_shift[c_PAYLOAD_W-1 -: BYTE_WIDTH];
                        r_shift  <= r_shift << BYTE_WIDTH;
                    end
                end
                S_PAY: begin
                    if (w_txFire) begin
                        if (r_cnt == c_LAST_BYTE) begin
                            if (r_pendValid) begin
                                r_state     <= S_HDR;
                                r_txData    <= r_pendCode;
                                r_shift     <= r_pendData;
                                r_pendValid <= 1'b0;
                            end else begin
                                r_state   <= S_IDLE;
                                r_txValid <= 1'b0;
                                r_txData  <= '0;
                            end
                        end else begin
                            r_cnt    <= r_cnt + 1'b1;
                            r_txData <= r_shift[c_PAYLOAD_W-1 -: BYTE_WIDTH];
                            r_shift  <= r_shift << BYTE_WIDTH;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_txValid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MSG_TELEMETRY_TXDATA_OutBus      = r_txData;
    assign bus.MSG_TELEMETRY_TXVALID_OutHigh    = r_txValid;
    assign bus.MSG_TELEMETRY_BUSY_OutHigh       = (r_state != S_IDLE) || r_pendValid;
    assign bus.MSG_TELEMETRY_WAYSELECT_OutBus   = r_waySelect;
    assign bus.MSG_TELEMETRY_STOPSIGNAL_OutLow  = r_stop;
    assign bus.MSG_TELEMETRY_BEGINSIGNAL_OutLow = r_begin;
    assign bus.MSG_TELEMETRY_DROP_OutHigh       = r_drop;
endmodule
`default_nettype wire

// File: tb/tb_message_telemetry_engine.sv
`default_nettype none
// =============================================================================
// Module   : tb_message_telemetry_engine
// Brief    : Directed bench with a queue-based reply model and per-cycle compare.
// Revision : 1.0 - initial release
// =============================================================================
module tb_message_telemetry_engine;
    localparam int BW = 8, WW = 17, BPW = 3, NW = 8, NC = 16;
    localparam int STOPC = 9, BEGC = 10, TBASE = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    message_telemetry_engine_if #(.BYTE_WIDTH(BW), .WORD_WIDTH(WW), .N_CHANNELS(NC), .N_WAYPOINTS(NW)) bus ();

    message_telemetry_engine #(
        .BYTE_WIDTH(BW), .WORD_WIDTH(WW), .BYTES_PER_WORD(BPW), .N_WAYPOINTS(NW),
        .N_CHANNELS(NC), .STOP_CODE(STOPC), .BEGIN_CODE(BEGC), .TELEM_BASE(TBASE)
    ) dut (
        .MSG_TELEMETRY_CLOCK_50    (clk),
        .MSG_TELEMETRY_RESET_InLow (rst_n),
        .bus                       (bus)
    );

    int nCompared = 0;
    int nFailed   = 0;

    logic [7:0] expQ[$];
    logic [7:0] txLog[$];
    int         hsCycle[$];
    int         cyc = 0;
    logic [2:0] mWay = '0;
    logic       mStop = 1'b0, mBegin = 1'b1, mDrop = 1'b0;
    logic       holdPrev = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFailed++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic checkLog(input string nm, input int n, input logic [63:0] exp);
        logic [63:0] acc;
        acc = '0;
        check({nm, "Len"}, 64'(txLog.size()), 64'(n));
        foreach (txLog[i]) acc = (acc << 8) | 64'(txLog[i]);
        check(nm, acc, exp);
    endtask

    // Reference model: replies are whole frames queued byte-wise; at most two outstanding.
    always @(posedge clk or negedge rst_n) begin
        int         code;
        logic [23:0] word;
        if (!rst_n) begin
            expQ.delete();
            mWay = '0; mStop = 1'b0; mBegin = 1'b1; mDrop = 1'b0;
        end else begin
            cyc++;
            mBegin = 1'b1;
            if (bus.MSG_TELEMETRY_RXVALID_InHigh) begin
                code = int'(bus.MSG_TELEMETRY_RXDATA_InBus);
                if (code >= 1 && code <= NW) mWay = 3'(code - 1);
                else if (code == STOPC) mStop = 1'b0;
                else if (code == BEGC) begin mStop = 1'b1; mBegin = 1'b0; end
                else if (code >= TBASE && code < TBASE + NC) begin
                    if ((expQ.size() + BPW) / (BPW + 1) < 2) begin
                        word = 24'(bus.MSG_TELEMETRY_CHANNELS_InBus[(code - TBASE)*WW +: WW]);
                        expQ.push_back(8'(code));
                        for (int b = BPW - 1; b >= 0; b--) expQ.push_back(8'(word >> (8*b)));
                    end else begin
                        mDrop = 1'b1;
                    end
                end
            end
            if (bus.MSG_TELEMETRY_TXVALID_OutHigh && bus.MSG_TELEMETRY_TXREADY_InHigh) begin
                txLog.push_back(bus.MSG_TELEMETRY_TXDATA_OutBus);
                hsCycle.push_back(cyc);
                if (expQ.size() > 0) void'(expQ.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        check("waySelect", 64'(bus.MSG_TELEMETRY_WAYSELECT_OutBus), 64'(mWay));
        check("stopSignal", 64'(bus.MSG_TELEMETRY_STOPSIGNAL_OutLow), 64'(mStop));
        check("beginSignal", 64'(bus.MSG_TELEMETRY_BEGINSIGNAL_OutLow), 64'(mBegin));
        check("drop", 64'(bus.MSG_TELEMETRY_DROP_OutHigh), 64'(mDrop));
        check("busy", 64'(bus.MSG_TELEMETRY_BUSY_OutHigh), 64'(expQ.size() > 0));
        if (expQ.size() == 0)
            check("txValidIdle", 64'(bus.MSG_TELEMETRY_TXVALID_OutHigh), 64'd0);
        else if (bus.MSG_TELEMETRY_TXVALID_OutHigh)
            check("txData", 64'(bus.MSG_TELEMETRY_TXDATA_OutBus), 64'(expQ[0]));
        if (holdPrev && rst_n)
            check("txHold", 64'(bus.MSG_TELEMETRY_TXVALID_OutHigh), 64'd1);
        holdPrev = rst_n && bus.MSG_TELEMETRY_TXVALID_OutHigh && !bus.MSG_TELEMETRY_TXREADY_InHigh;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] code);
        bus.MSG_TELEMETRY_RXVALID_InHigh = 1'b1;
        bus.MSG_TELEMETRY_RXDATA_InBus   = code;
        tick();
        bus.MSG_TELEMETRY_RXVALID_InHigh = 1'b0;
        bus.MSG_TELEMETRY_RXDATA_InBus   = '0;
    endtask

    task automatic waitIdle(input string nm, input int bound);
        int n;
        n = 0;
        while (bus.MSG_TELEMETRY_BUSY_OutHigh && n < bound) begin
            tick();
            n++;
        end
        check(nm, 64'(bus.MSG_TELEMETRY_BUSY_OutHigh), 64'd0);
    endtask

    task automatic clearLogs();
        txLog.delete();
        hsCycle.delete();
    endtask

    initial begin
        bus.MSG_TELEMETRY_RXVALID_InHigh = 1'b0;
        bus.MSG_TELEMETRY_RXDATA_InBus   = '0;
        bus.MSG_TELEMETRY_CHANNELS_InBus = '0;
        bus.MSG_TELEMETRY_TXREADY_InHigh = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rstWay", 64'(bus.MSG_TELEMETRY_WAYSELECT_OutBus), 64'd0);
        check("rstStop", 64'(bus.MSG_TELEMETRY_STOPSIGNAL_OutLow), 64'd0);
        check("rstBegin", 64'(bus.MSG_TELEMETRY_BEGINSIGNAL_OutLow), 64'd1);
        check("rstTxValid", 64'(bus.MSG_TELEMETRY_TXVALID_OutHigh), 64'd0);
        check("rstTxData", 64'(bus.MSG_TELEMETRY_TXDATA_OutBus), 64'd0);
        check("rstBusy", 64'(bus.MSG_TELEMETRY_BUSY_OutHigh), 64'd0);
        check("rstDrop", 64'(bus.MSG_TELEMETRY_DROP_OutHigh), 64'd0);
        rst_n = 1'b1;
        tick();

        // Control commands
        send(8'd3);
        check("way3", 64'(bus.MSG_TELEMETRY_WAYSELECT_OutBus), 64'd2);
        send(8'd10);
        check("beginLow", 64'(bus.MSG_TELEMETRY_BEGINSIGNAL_OutLow), 64'd0);
        check("stopReleased", 64'(bus.MSG_TELEMETRY_STOPSIGNAL_OutLow), 64'd1);
        tick();
        check("beginHigh", 64'(bus.MSG_TELEMETRY_BEGINSIGNAL_OutLow), 64'd1);
        send(8'd9);
        check("stopped", 64'(bus.MSG_TELEMETRY_STOPSIGNAL_OutLow), 64'd0);
        check("wayKept", 64'(bus.MSG_TELEMETRY_WAYSELECT_OutBus), 64'd2);

        // Single reply, sink always ready
        bus.MSG_TELEMETRY_CHANNELS_InBus[5*WW +: WW] = 17'h1ABCD;
        bus.MSG_TELEMETRY_TXREADY_InHigh = 1'b1;
        clearLogs();
        send(8'd37);
        check("latency", 64'(bus.MSG_TELEMETRY_TXVALID_OutHigh), 64'd1);
        check("hdrEcho", 64'(bus.MSG_TELEMETRY_TXDATA_OutBus), 64'h25);
        waitIdle("idleSeq1", 20);
        checkLog("seq1", 4, 64'h2501ABCD);
        check("seq1Span", 64'(hsCycle.size() == 4 ? hsCycle[3] - hsCycle[0] : -1), 64'd3);

        // Throttled sink; snapshot must survive a channel change
        bus.MSG_TELEMETRY_TXREADY_InHigh = 1'b0;
        clearLogs();
        send(8'd37);
        bus.MSG_TELEMETRY_CHANNELS_InBus[5*WW +: WW] = 17'h0;
        for (int i = 0; i < 40 && bus.MSG_TELEMETRY_BUSY_OutHigh; i++) begin
            bus.MSG_TELEMETRY_TXREADY_InHigh = ~bus.MSG_TELEMETRY_TXREADY_InHigh;
            tick();
        end
        check("idleToggle", 64'(bus.MSG_TELEMETRY_BUSY_OutHigh), 64'd0);
        checkLog("seqToggle", 4, 64'h2501ABCD);
        check("toggleSpan", 64'(hsCycle.size() == 4 ? hsCycle[3] - hsCycle[0] : -1), 64'd6);

        // Pending slot, back-to-back reply and drop
        bus.MSG_TELEMETRY_CHANNELS_InBus[5*WW +: WW] = 17'h1ABCD;
        bus.MSG_TELEMETRY_CHANNELS_InBus[1*WW +: WW] = 17'h00042;
        bus.MSG_TELEMETRY_CHANNELS_InBus[2*WW +: WW] = 17'h1FFFF;
        bus.MSG_TELEMETRY_TXREADY_InHigh = 1'b0;
        clearLogs();
        send(8'd37);
        send(8'd33);
        send(8'd34);
        check("dropSticky", 64'(bus.MSG_TELEMETRY_DROP_OutHigh), 64'd1);
        check("busyPend", 64'(bus.MSG_TELEMETRY_BUSY_OutHigh), 64'd1);
        bus.MSG_TELEMETRY_TXREADY_InHigh = 1'b1;
        waitIdle("idleB2B", 30);
        checkLog("seqB2B", 8, 64'h2501ABCD21000042);
        check("backToBack", 64'(hsCycle.size() == 8 ? hsCycle[4] - hsCycle[3] : -1), 64'd1);

        // Ignored codes, then a waypoint change while the payload is going out
        clearLogs();
        send(8'd0);
        send(8'd15);
        send(8'd48);
        check("ignoredValid", 64'(bus.MSG_TELEMETRY_TXVALID_OutHigh), 64'd0);
        check("ignoredBusy", 64'(bus.MSG_TELEMETRY_BUSY_OutHigh), 64'd0);
        check("ignoredWay", 64'(bus.MSG_TELEMETRY_WAYSELECT_OutBus), 64'd2);
        send(8'd37);
        tick();
        send(8'd6);
        check("wayInPay", 64'(bus.MSG_TELEMETRY_WAYSELECT_OutBus), 64'd5);
        check("payValid", 64'(bus.MSG_TELEMETRY_TXVALID_OutHigh), 64'd1);
        waitIdle("idleWay", 20);
        checkLog("seqWay", 4, 64'h2501ABCD);

        // Asynchronous reset in the middle of the payload
        clearLogs();
        send(8'd37);
        tick();
        bus.MSG_TELEMETRY_TXREADY_InHigh = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("abortValid", 64'(bus.MSG_TELEMETRY_TXVALID_OutHigh), 64'd0);
        check("abortStop", 64'(bus.MSG_TELEMETRY_STOPSIGNAL_OutLow), 64'd0);
        check("abortWay", 64'(bus.MSG_TELEMETRY_WAYSELECT_OutBus), 64'd0);
        check("abortBusy", 64'(bus.MSG_TELEMETRY_BUSY_OutHigh), 64'd0);
        check("abortDrop", 64'(bus.MSG_TELEMETRY_DROP_OutHigh), 64'd0);
        clearLogs();
        bus.MSG_TELEMETRY_TXREADY_InHigh = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (10) tick();
        checkLog("afterReset", 0, 64'd0);
        check("quietValid", 64'(bus.MSG_TELEMETRY_TXVALID_OutHigh), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
